// File: rtl/ahb_mc_pkg.sv
// Shared encodings for the multi-channel AHB slave front end.
package ahb_mc_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    ERR1 = 2'b10,
    ERR2 = 2'b11
  } state_t;

endpackage

// File: rtl/ahb_addr_decoder.sv
// Peripheral window decoder: one-hot channel select plus hit flag.
module ahb_addr_decoder #(
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h8000_0000,
  parameter int                SLV_SIZE_LOG2 = 26,
  parameter int                NUM_SLV       = 3
) (
  input  logic [ADDR_W-1:0]  haddr_i,
  output logic [NUM_SLV-1:0] tempselx_o,
  output logic               hit_o
);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx;

  // Addresses below the window wrap to a large offset; the explicit
  // lower-bound compare keeps them from aliasing into a channel.
  always_comb begin
    off        = haddr_i - BASE_ADDR;
    idx        = off >> SLV_SIZE_LOG2;
    hit_o      = (haddr_i >= BASE_ADDR) && (idx < ADDR_W'(NUM_SLV));
    tempselx_o = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      tempselx_o[i] = hit_o && (idx == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/ahb_slave_if_mc.sv
// AHB slave front end for the APB bridge: decode, pipelines, wait states
// and two-cycle ERROR response for unmapped accesses.
//
//   state | meaning
//   IDLE  | no data phase outstanding, ready with OKAY
//   DATA  | data phase of a mapped transfer, ready follows Pready
//   ERR1  | first ERROR cycle, not ready
//   ERR2  | second ERROR cycle, ready; may accept a new transfer
module ahb_slave_if_mc
  import ahb_mc_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                NUM_SLV       = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h8000_0000,
  parameter int                SLV_SIZE_LOG2 = 26,
  parameter int                ERR_CNT_W     = 8
) (
  input  logic                 Hclk,
  input  logic                 Hrst,
  input  logic                 Hwrite,
  input  logic                 Hreadyin,
  input  logic [1:0]           Htrans,
  input  logic [ADDR_W-1:0]    Haddr,
  input  logic [DATA_W-1:0]    Hwdata,
  input  logic [DATA_W-1:0]    Prdata,
  input  logic                 Pready,
  output logic                 valid,
  output logic [ADDR_W-1:0]    Haddr1,
  output logic [ADDR_W-1:0]    Haddr2,
  output logic [DATA_W-1:0]    Hwdata1,
  output logic [DATA_W-1:0]    Hwdata2,
  output logic                 Hwritereg,
  output logic [NUM_SLV-1:0]   tempselx,
  output logic [NUM_SLV-1:0]   selx_reg,
  output logic [DATA_W-1:0]    Hrdata,
  output logic [1:0]           Hresp,
  output logic                 Hreadyout,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic                 hit;
  logic                 accept;
  state_t               state_q, state_d, issue_state;
  logic                 valid_q;
  logic [ADDR_W-1:0]    haddr1_q, haddr2_q;
  logic [DATA_W-1:0]    hwdata1_q, hwdata2_q;
  logic                 hwrite_q;
  logic [NUM_SLV-1:0]   selx_q;
  logic [ERR_CNT_W-1:0] err_q;

  ahb_addr_decoder #(
    .ADDR_W        (ADDR_W),
    .BASE_ADDR     (BASE_ADDR),
    .SLV_SIZE_LOG2 (SLV_SIZE_LOG2),
    .NUM_SLV       (NUM_SLV)
  ) u_dec (
    .haddr_i    (Haddr),
    .tempselx_o (tempselx),
    .hit_o      (hit)
  );

  assign accept = Hreadyin && Htrans[1];

  // Pipelines stall with Hreadyin; transfer attributes latch only on accept.
  always_ff @(posedge Hclk) begin
    if (Hrst) begin
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite_q  <= 1'b0;
      selx_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      if (Hreadyin) begin
        haddr1_q  <= Haddr;
        haddr2_q  <= haddr1_q;
        hwdata1_q <= Hwdata;
        hwdata2_q <= hwdata1_q;
      end
      if (accept) begin
        hwrite_q <= Hwrite;
        selx_q   <= tempselx;
      end
      valid_q <= accept && hit;
      if (accept && !hit && (err_q != '1)) begin
        err_q <= err_q + ERR_CNT_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge Hclk) begin
    if (Hrst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state shared by IDLE, a completing DATA and ERR2.
  always_comb begin
    issue_state = IDLE;
    if (accept) issue_state = hit ? DATA : ERR1;
  end

  // Next-state and response outputs.
  always_comb begin
    state_d   = state_q;
    Hreadyout = 1'b1;
    Hresp     = HRESP_OKAY;
    case (state_q)
      IDLE: state_d = issue_state;
      DATA: begin
        Hreadyout = Pready;
        if (Pready) state_d = issue_state;
      end
      ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = HRESP_ERROR;
        state_d   = ERR2;
      end
      ERR2: begin
        Hresp   = HRESP_ERROR;
        state_d = issue_state;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Hrdata    = ((state_q == DATA) && !hwrite_q) ? Prdata : '0;
  assign valid     = valid_q;
  assign Haddr1    = haddr1_q;
  assign Haddr2    = haddr2_q;
  assign Hwdata1   = hwdata1_q;
  assign Hwdata2   = hwdata2_q;
  assign Hwritereg = hwrite_q;
  assign selx_reg  = selx_q;
  assign err_count = err_q;

endmodule

// File: doc/ahb_slave_if_mc.md
Name: ahb_slave_if_mc

Overview:
Parametrised successor to the bridge's AHB slave front end. It decodes an N-channel peripheral address map and registers the address, data and control pipelines. Unlike its predecessor, it honours downstream wait states via Pready/Hreadyout and returns an AHB two-cycle ERROR for unmapped accesses. It sits between the AHB interconnect and the APB bridge FSM, which consumes valid, the pipelined address/data and the select bits.

Parameters:
ADDR_W, 32, address bus width
DATA_W, 32, data bus width
NUM_SLV, 3, number of peripheral channels (1..8)
BASE_ADDR, 32'h8000_0000, start of peripheral window
SLV_SIZE_LOG2, 26, log2 of the bytes per channel (64 MB)
ERR_CNT_W, 8, width of the unmapped-access counter

Ports:
Hclk  in  1  clock
Hrst  in  1  synchronous reset, active-high
Hwrite  in  1  AHB write
Hreadyin  in  1  global HREADY
Htrans  in  2  AHB transfer type
Haddr  in  ADDR_W  AHB address
Hwdata  in  DATA_W  AHB write data
Prdata  in  DATA_W  read data from the bridge
Pready  in  1  bridge completes the current data phase
valid  out  1  registered pulse: accepted in-range transfer
Haddr1  out  ADDR_W  address, stage 1
Haddr2  out  ADDR_W  address, stage 2
Hwdata1  out  DATA_W  write data, stage 1
Hwdata2  out  DATA_W  write data, stage 2
Hwritereg  out  1  Hwrite registered at accept
tempselx  out  NUM_SLV  combinational one-hot decode of Haddr
selx_reg  out  NUM_SLV  tempselx registered at accept
Hrdata  out  DATA_W  AHB read data
Hresp  out  2  00 OKAY, 01 ERROR
Hreadyout  out  1  slave ready
err_count  out  ERR_CNT_W  saturating count of unmapped accesses

Behaviour:
- One clock (Hclk). Reset (Hrst) is synchronous and active-high; it is sampled on the Hclk rising edge.
- Reset values: all registered outputs are 0, err_count is 0, the FSM is in IDLE (so Hreadyout=1 and Hresp=00 on the cycle after reset). A reset mid-transfer abandons the transfer; nothing is replayed.
- Decode (combinational):
  - off = Haddr - BASE_ADDR; idx = off >> SLV_SIZE_LOG2.
  - hit = (Haddr >= BASE_ADDR) && (idx < NUM_SLV).
  - tempselx = one-hot bit idx when hit, otherwise all zeros.
  - The subtraction is done at ADDR_W width; a Haddr below BASE_ADDR is a miss regardless of any wrap.
- accept = Hreadyin && Htrans[1] (NONSEQ or SEQ). IDLE and BUSY transfers always get a zero-wait OKAY and have no side effects.
- Pipelines, all enabled only when Hreadyin=1 so they hold during wait states:
  - Haddr1 <= Haddr; Haddr2 <= Haddr1.
  - Hwdata1 <= Hwdata; Hwdata2 <= Hwdata1.
- Registered at accept: Hwritereg <= Hwrite; selx_reg <= tempselx.
- valid <= accept && hit. It is a single-cycle pulse per accepted transfer.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE: Hreadyout=1, Hresp=00. accept&&hit -> DATA; accept&&!hit -> ERR1; otherwise stay.
  - DATA: Hreadyout=Pready, Hresp=00. While Pready=0, stay in DATA. With Pready=1, apply the same next-state rule as IDLE, so back-to-back pipelined transfers are supported.
  - ERR1: Hreadyout=0, Hresp=01 -> ERR2 unconditionally.
  - ERR2: Hreadyout=1, Hresp=01. Then apply the IDLE next-state rule. A transfer presented in ERR2 is accepted normally.
- Hrdata = Prdata when state==DATA and Hwritereg=0, otherwise 0.
- err_count increments on each accept&&!hit and saturates at all-ones.

Decomposition:
- Package ahb_mc_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/HRESP_ERROR
  - the state typedef (IDLE, DATA, ERR1, ERR2)
- Sub-module ahb_addr_decoder (parameters BASE_ADDR, SLV_SIZE_LOG2, NUM_SLV) produces tempselx and hit.

Test Plan:
- Reset: hold Hrst=1 for 2 cycles mid-DATA with Pready=0 -> the next cycle shows Hreadyout=1, Hresp=00, valid=0, err_count=0.
- NONSEQ write to 0x8400_0010, Pready=1 -> tempselx=3'b010, valid=1 next cycle, selx_reg=3'b010, Hwritereg=1, Haddr1=0x8400_0010.
- NONSEQ read to 0x8000_0004 with Pready low for 3 cycles -> Hreadyout low for 3 cycles; Haddr1, Haddr2 and Hwdata1 hold; Hrdata=Prdata (e.g. 0xDEAD_BEEF) when Pready=1.
- NONSEQ to 0x8C00_0000, then 0x7FFF_FFFC -> each gives ERR1 (Hreadyout=0, Hresp=01) then ERR2 (Hreadyout=1, Hresp=01); valid stays 0; err_count goes 1 then 2.
- Back-to-back NONSEQ/SEQ to 0x8800_0000 and 0x8800_0004 -> two valid pulses, DATA persists, selx_reg=3'b100; an IDLE Htrans between them gives no valid pulse.
- NUM_SLV=8, ERR_CNT_W=2: 5 misses -> err_count saturates at 3; an access at 0x9C00_0000 decodes to tempselx[7].
